float_arg_min: RTL

//  Streaming IEEE-754 arg-min reduction unit for the Versat datapath.

---
 rtl/float_arg_min.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/float_arg_min.sv
// rtl/float_arg_min.sv - streaming IEEE-754 arg-min reduction (value + index) over a masked run.
// Optional nan_seen output enabled by defining FLOAT_ARG_MIN_NAN_FLAG_EN.
module float_arg_min #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic              run,
    input  logic [CNT_W-1:0]  length,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              start,
    output logic              done,
    output logic [DATA_W-1:0] out0,
    output logic [CNT_W-1:0]  out1
`ifdef FLOAT_ARG_MIN_NAN_FLAG_EN
    ,
    output logic              nan_seen
`endif
);

    localparam int MANT_W = DATA_W - 1 - EXP_W;
    localparam logic [DATA_W-1:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    localparam logic [CNT_W-1:0]  NO_CAND = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [CNT_W-1:0]  out1_q, out1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              done_q, done_d;
    logic              nan_seen_q, nan_seen_d;

    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_nan;
    logic              accept;
    logic              in_less;
    logic [CNT_W-1:0]  cnt_inc;

    // Sign-magnitude order; -0 sorts below +0 because the signs differ.
    function automatic logic less_than(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-2:0] ma;
        logic [DATA_W-2:0] mb;
        ma = a[DATA_W-2:0];
        mb = b[DATA_W-2:0];
        if (a[DATA_W-1] != b[DATA_W-1]) begin
            return a[DATA_W-1];
        end else if (a[DATA_W-1]) begin
            return ma > mb;
        end else begin
            return ma < mb;
        end
    endfunction

    assign in_exp  = in0[DATA_W-2 -: EXP_W];
    assign in_mant = in0[MANT_W-1:0];
    assign in_nan  = (&in_exp) && (|in_mant);
    assign accept  = (state_q == ACCUM) && running && (|in1) && !run;
    assign in_less = less_than(in0, out0_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        done_d     = done_q;
        nan_seen_d = nan_seen_q;

        if (run) begin
            // A restart wins over any sample presented in the same cycle.
            state_d    = (length == '0) ? DONE : ACCUM;
            out0_d     = POS_INF;
            out1_d     = NO_CAND;
            cnt_d      = '0;
            idx_d      = '0;
            len_d      = length;
            done_d     = (length == '0);
            nan_seen_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_inc;
            idx_d = idx_q + CNT_W'(1);
            if (in_nan) begin
                nan_seen_d = 1'b1;
            end else if ((out1_q == NO_CAND) || in_less) begin
                out0_d = in0;
                out1_d = idx_q;
            end
            if (cnt_inc == len_q) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            out0_q     <= '0;
            out1_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            nan_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            done_q     <= done_d;
            nan_seen_q <= nan_seen_d;
        end
    end

    assign done = done_q;
    assign out0 = out0_q;
    assign out1 = out1_q;

`ifdef FLOAT_ARG_MIN_NAN_FLAG_EN
    assign nan_seen = nan_seen_q;
    logic unused_start;
    assign unused_start = start;
`else
    logic unused_sigs;
    assign unused_sigs = start ^ nan_seen_q;
`endif

endmodule
